// File: rtl/tile_loop_scheduler_pkg.sv
// Shared definitions for the tile loop scheduler and its tile counter.
package tile_loop_scheduler_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_RELEASE = 3'd2,
    S_ADVANCE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Core controller handshake levels (all active-high).
  localparam logic CORE_START_ON  = 1'b1;
  localparam logic CORE_START_OFF = 1'b0;
  localparam logic CORE_DONE_ACT  = 1'b1;
  localparam logic CORE_IDLE_ACT  = 1'b1;

  // True while a tile is owned by the scheduler (issued and not yet retired).
  function automatic logic tile_active(input state_t s);
    return (s == S_ISSUE) || (s == S_RELEASE) || (s == S_ADVANCE);
  endfunction

endpackage

// File: rtl/tile_loop_scheduler_counter.sv
// Nested tile counter: k is the inner loop, n increments when k wraps.
module tile_counter_2d
  import tile_loop_scheduler_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step,
  input  logic [CNT_W-1:0] n_tiles,
  input  logic [CNT_W-1:0] k_tiles,
  output logic [CNT_W-1:0] n_idx,
  output logic [CNT_W-1:0] k_idx,
  output logic             first_k,
  output logic             last_k,
  output logic             wrap
);

  logic last_n;

  assign first_k = (k_idx == '0);
  assign last_k  = (k_idx == k_tiles - CNT_W'(1));
  assign last_n  = (n_idx == n_tiles - CNT_W'(1));
  // Terminal count: the current tile is the last of the whole 2D loop.
  assign wrap    = last_k && last_n;

  // Index registers: cleared on reset or layer start, stepped once per retired tile.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      n_idx <= '0;
      k_idx <= '0;
    end else if (step) begin
      if (last_k) begin
        k_idx <= '0;
        n_idx <= n_idx + CNT_W'(1);
      end else begin
        k_idx <= k_idx + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tile_loop_scheduler.sv
// Layer-level sequencer: issues one core start per (n, k) tile and reports
// a single busy/done/err status for the whole layer.
module tile_loop_scheduler
  import tile_loop_scheduler_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [CNT_W-1:0]  cfg_n_tiles,
  input  logic [CNT_W-1:0]  cfg_k_tiles,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W-1:0] cfg_w_stride,
  output logic              sched_idle,
  output logic              sched_done,
  output logic              sched_err,
  output logic              core_start,
  input  logic              core_done,
  input  logic              core_idle,
  output logic [ADDR_W-1:0] core_w_addr,
  output logic              core_acc_clear,
  output logic              core_acc_last,
  output logic [CNT_W-1:0]  n_idx,
  output logic [CNT_W-1:0]  k_idx
);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  n_tiles_q, k_tiles_q;
  logic [ADDR_W-1:0] stride_q, addr_q;
  logic              abort_pend;
  logic              start_acc, zero_cnt, step, set_err;
  logic              first_k, last_k, last_tile;

  assign zero_cnt = (cfg_n_tiles == '0) || (cfg_k_tiles == '0);

  tile_counter_2d #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_acc),
    .step    (step),
    .n_tiles (n_tiles_q),
    .k_tiles (k_tiles_q),
    .n_idx   (n_idx),
    .k_idx   (k_idx),
    .first_k (first_k),
    .last_k  (last_k),
    .wrap    (last_tile)
  );

  // State register; reset returns to IDLE immediately, dropping core_start.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nx   = state;
    core_start = CORE_START_OFF;
    sched_idle = 1'b0;
    sched_done = 1'b0;
    start_acc  = 1'b0;
    step       = 1'b0;
    set_err    = 1'b0;
    case (state)
      S_IDLE: begin
        sched_idle = 1'b1;
        if (cfg_start) begin
          start_acc = 1'b1;
          state_nx  = zero_cnt ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        core_start = CORE_START_ON;
        if (core_done == CORE_DONE_ACT) state_nx = S_RELEASE;
      end
      S_RELEASE: begin
        if (core_idle == CORE_IDLE_ACT) state_nx = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (abort_pend || cfg_abort) begin
          set_err  = 1'b1;
          state_nx = S_DONE;
        end else if (last_tile) begin
          state_nx = S_DONE;
        end else begin
          step     = 1'b1;
          state_nx = S_ISSUE;
        end
      end
      S_DONE: begin
        sched_done = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Layer bounds latched at start so later cfg_* changes have no effect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_tiles_q <= '0;
      k_tiles_q <= '0;
      stride_q  <= '0;
    end else if (start_acc) begin
      n_tiles_q <= cfg_n_tiles;
      k_tiles_q <= cfg_k_tiles;
      stride_q  <= cfg_w_stride;
    end
  end

  // Weight address accumulator; wraps modulo 2^ADDR_W without flagging.
  always_ff @(posedge clk) begin
    if (!rst_n)         addr_q <= '0;
    else if (start_acc) addr_q <= cfg_w_base;
    else if (step)      addr_q <= addr_q + stride_q;
  end

  // Abort is only recorded here; it takes effect at the next tile boundary.
  always_ff @(posedge clk) begin
    if (!rst_n)                                abort_pend <= 1'b0;
    else if (start_acc)                        abort_pend <= 1'b0;
    else if (cfg_abort && tile_active(state))  abort_pend <= 1'b1;
  end

  // Sticky error: zero-count layer or honoured abort; cleared by the next start.
  always_ff @(posedge clk) begin
    if (!rst_n)         sched_err <= 1'b0;
    else if (start_acc) sched_err <= zero_cnt;
    else if (set_err)   sched_err <= 1'b1;
  end

  assign core_w_addr    = addr_q;
  assign core_acc_clear = tile_active(state) && first_k;
  assign core_acc_last  = tile_active(state) && last_k;

endmodule

// File: tb/tb_tile_loop_scheduler.sv
// Scoreboard bench: stimulus pushes expected tiles/completions, a monitor
// pops and compares whenever the scheduler starts a tile or signals done.
module tb_tile_loop_scheduler;

  localparam int CNT_W  = 16;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, cfg_start, cfg_abort;
  logic [CNT_W-1:0]  cfg_n_tiles, cfg_k_tiles;
  logic [ADDR_W-1:0] cfg_w_base, cfg_w_stride;
  logic              sched_idle, sched_done, sched_err, core_start;
  logic              core_done, core_idle, core_acc_clear, core_acc_last;
  logic [ADDR_W-1:0] core_w_addr;
  logic [CNT_W-1:0]  n_idx, k_idx;

  tile_loop_scheduler #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_n_tiles(cfg_n_tiles), .cfg_k_tiles(cfg_k_tiles),
    .cfg_w_base(cfg_w_base), .cfg_w_stride(cfg_w_stride),
    .sched_idle(sched_idle), .sched_done(sched_done), .sched_err(sched_err),
    .core_start(core_start), .core_done(core_done), .core_idle(core_idle),
    .core_w_addr(core_w_addr), .core_acc_clear(core_acc_clear),
    .core_acc_last(core_acc_last), .n_idx(n_idx), .k_idx(k_idx)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              clr;
    logic              last;
    logic [CNT_W-1:0]  n;
    logic [CNT_W-1:0]  k;
  } tile_t;

  tile_t exp_tiles[$];
  bit    exp_done[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    done_dly = -1;
  int    idle_gap = -1;
  bit    extra_done = 1'b0;
  int    done_cyc = 0;
  int    last_done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: tile t of the layer has k = t mod K, n = t div K,
  // address base + t*stride; an abort stops after the tile it lands in.
  task automatic expect_layer(input int n, input int k, input logic [ADDR_W-1:0] base,
                              input logic [ADDR_W-1:0] stride, input int abort_tile);
    int total;
    int issued;
    tile_t x;
    total  = n * k;
    issued = (abort_tile >= 0 && abort_tile < total) ? abort_tile + 1 : total;
    for (int t = 0; t < issued; t++) begin
      x.addr = base + stride * ADDR_W'(t);
      x.n    = CNT_W'(t / k);
      x.k    = CNT_W'(t % k);
      x.clr  = ((t % k) == 0);
      x.last = ((t % k) == k - 1);
      exp_tiles.push_back(x);
    end
    exp_done.push_back((total == 0) || (abort_tile >= 0));
  endtask

  task automatic start_layer(input int n, input int k, input logic [ADDR_W-1:0] base,
                             input logic [ADDR_W-1:0] stride);
    @(negedge clk);
    cfg_n_tiles  = CNT_W'(n);
    cfg_k_tiles  = CNT_W'(k);
    cfg_w_base   = base;
    cfg_w_stride = stride;
    cfg_start    = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    if (n == 0 || k == 0) begin
      chk("zero_done_at_T1", sched_done, 1'b1);
      chk("zero_core_start", core_start, 1'b0);
    end else begin
      chk("start_latency", core_start, 1'b1);
      chk("first_addr", core_w_addr, base);
    end
    chk("err_on_start", sched_err, (n == 0 || k == 0));
    cfg_n_tiles  = CNT_W'($urandom);
    cfg_k_tiles  = CNT_W'($urandom);
    cfg_w_base   = $urandom;
    cfg_w_stride = $urandom;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (sched_idle && core_idle && exp_done.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle timeout actual=busy required=idle");
    end
    chk("tiles_left", exp_tiles.size(), 0);
  endtask

  task automatic wait_tile(input int n, input int k, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (core_start && n_idx == CNT_W'(n) && k_idx == CNT_W'(k)) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_tile timeout n=%0d k=%0d", n, k);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_sched_idle", sched_idle, 1'b1);
    chk("rst_sched_done", sched_done, 1'b0);
    chk("rst_sched_err", sched_err, 1'b0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_core_w_addr", core_w_addr, 0);
    chk("rst_acc_clear", core_acc_clear, 1'b0);
    chk("rst_acc_last", core_acc_last, 1'b0);
    chk("rst_n_idx", n_idx, 0);
    chk("rst_k_idx", k_idx, 0);
  endtask

  // Core controller model: busy on start, one done pulse, idle again later.
  initial begin : core_model
    int d;
    int g;
    core_done = 1'b0;
    core_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (core_start === 1'b1 && core_idle) begin
        d = (done_dly < 0) ? int'($urandom_range(0, 3)) : done_dly;
        g = (idle_gap < 0) ? int'($urandom_range(0, 2)) : idle_gap;
        core_idle = 1'b0;
        repeat (d) @(negedge clk);
        core_done = 1'b1;
        done_cyc  = cyc;
        @(negedge clk);
        core_done = 1'b0;
        if (extra_done) begin
          core_done = 1'b1;
          @(negedge clk);
          core_done = 1'b0;
        end
        repeat (g) @(negedge clk);
        core_idle = 1'b1;
      end
    end
  end

  // Monitor: pops an expected tile on each new core_start and an expected
  // error flag on each sched_done.
  initial begin : monitor
    tile_t cur;
    bit    have;
    bit    prev_start;
    bit    prev_done;
    have = 1'b0;
    prev_start = 1'b0;
    prev_done = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      #1;
      if (core_start === 1'b1) begin
        if (!prev_start) begin
          if (exp_tiles.size() == 0) begin
            checks++;
            errors++;
            have = 1'b0;
            $display("FAIL unexpected_core_start actual n=%0d k=%0d required=none", n_idx, k_idx);
          end else begin
            cur  = exp_tiles.pop_front();
            have = 1'b1;
          end
        end
        if (have) begin
          chk("tile_addr", core_w_addr, cur.addr);
          chk("tile_acc_clear", core_acc_clear, cur.clr);
          chk("tile_acc_last", core_acc_last, cur.last);
          chk("tile_n_idx", n_idx, cur.n);
          chk("tile_k_idx", k_idx, cur.k);
        end
      end
      if (prev_done) chk("idle_after_done", sched_idle, 1'b1);
      if (sched_done === 1'b1) begin
        last_done_cyc = cyc;
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sched_done actual=1 required=0");
        end else begin
          chk("sched_err", sched_err, exp_done.pop_front());
        end
      end
      prev_start = (core_start === 1'b1);
      prev_done  = (sched_done === 1'b1);
    end
  end

  initial begin : stim
    int n;
    int k;
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] s;
    rst_n = 1'b0;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cfg_n_tiles = '0;
    cfg_k_tiles = '0;
    cfg_w_base = '0;
    cfg_w_stride = '0;
    repeat (2) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    // Basic 2x3 layer.
    expect_layer(2, 3, 32'h1000, 32'h100, -1);
    start_layer(2, 3, 32'h1000, 32'h100);
    wait_idle(400);

    // Zero counts.
    expect_layer(0, 4, 32'h2000, 32'h10, -1);
    start_layer(0, 4, 32'h2000, 32'h10);
    wait_idle(20);
    expect_layer(3, 0, 32'h2000, 32'h10, -1);
    start_layer(3, 0, 32'h2000, 32'h10);
    wait_idle(20);

    // Abort during tile 1 of a 1x4 layer.
    expect_layer(1, 4, 32'h4000, 32'h40, 1);
    start_layer(1, 4, 32'h4000, 32'h40);
    wait_tile(0, 1, 100);
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    wait_idle(200);

    // Single tile with fixed core timing; also the start that clears err.
    done_dly = 0;
    idle_gap = 1;
    expect_layer(1, 1, 32'h8000, 32'h80, -1);
    start_layer(1, 1, 32'h8000, 32'h80);
    wait_idle(100);
    chk("done_latency", last_done_cyc - done_cyc, 4);
    done_dly = -1;
    idle_gap = -1;

    // Reset in the middle of tile 2, then a clean rerun from base.
    expect_layer(2, 2, 32'hA000, 32'h20, -1);
    start_layer(2, 2, 32'hA000, 32'h20);
    wait_tile(1, 0, 200);
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    check_reset_values();
    exp_tiles.delete();
    exp_done.delete();
    rst_n = 1'b1;
    wait_idle(50);
    expect_layer(2, 2, 32'hA000, 32'h20, -1);
    start_layer(2, 2, 32'hA000, 32'h20);
    wait_idle(300);

    // Address wrap with spurious core_done and cfg_start pulses mid-layer.
    extra_done = 1'b1;
    expect_layer(1, 2, 32'hFFFF_FF00, 32'h100, -1);
    start_layer(1, 2, 32'hFFFF_FF00, 32'h100);
    cfg_start = 1'b1;
    repeat (2) @(negedge clk);
    cfg_start = 1'b0;
    wait_idle(200);
    extra_done = 1'b0;

    // Randomized layers; an abort pulse in IDLE must be ignored.
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 3));
      k = int'($urandom_range(1, 4));
      b = $urandom;
      s = $urandom;
      @(negedge clk);
      cfg_abort = 1'b1;
      @(negedge clk);
      cfg_abort = 1'b0;
      expect_layer(n, k, b, s, -1);
      start_layer(n, k, b, s);
      wait_idle(600);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
